regfile_multiport: RTL and testbench

- Parametrised successor to the core's single-write, dual-read register file.
- Adds:
  - N read ports
  - hardwired-zero entry 0
  - same-cycle write-to-read bypass
  - a per-entry busy scoreboard for in-flight producers
  - a post-reset clear sequencer, so the array never reads as X
- Sits in decode/writeback of the pipelined core; hazard logic consumes the busy flags.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_multiport.sv | 147 ++++++++++++++
 tb/tb_regfile_multiport.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: the clear/run state
// encoding, the address-width helper and the hardwired-zero entry index.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_ZERO_IDX = 0;

    // Address width for a given depth; never narrower than one bit
    function automatic int rf_addr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per entry marks a producer in flight.
// Priority per entry: flush clears all, then reserve sets, then write clears.
// Entry 0 never reads busy; a read bypassed from the write port is not busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int AW    = rf_addr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_l_i,
    input  logic                  run_i,
    input  logic                  flush_i,
    input  logic                  rsv_en_i,
    input  logic [AW-1:0]         rsv_addr_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [NUM_RD*AW-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0]     rd_busy_o
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_IDX);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next-state of every busy bit with flush > reserve > write priority
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!run_i) begin
                busy_d[i] = busy_q[i];
            end else if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (rsv_en_i && (32'(rsv_addr_i) == i)) begin
                busy_d[i] = 1'b1;
            end else if (wr_en_i && (32'(wr_addr_i) == i)) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        busy_d[RF_ZERO_IDX] = 1'b0;
    end

    // Busy-bit storage, cleared by reset
    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_port
            logic [AW-1:0] addr_s;
            logic          valid_s;
            logic          hit_s;
            assign addr_s  = rd_addr_i[p*AW +: AW];
            assign valid_s = run_i && (addr_s != ZERO_ADDR) && (32'(addr_s) < DEPTH);
            assign hit_s   = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_s);
            assign rd_busy_o[p] = valid_s ? (busy_q[addr_s] & ~hit_s) : 1'b0;
        end
    endgenerate

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with hardwired-zero entry 0, optional same-cycle
// write-to-read bypass, busy scoreboard and a post-reset clear sequencer.
// Optional feature: define REGFILE_PARITY_EN to store an even-parity bit per
// entry and report per-port read parity errors.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    localparam int AW        = rf_addr_width(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          reset_l_i,
    input  logic [NUM_RD*AW-1:0]          rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]             rd_busy_o,
    input  logic                          wr_en_i,
    input  logic [AW-1:0]                 wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rsv_en_i,
    input  logic [AW-1:0]                 rsv_addr_i,
    input  logic                          flush_i,
    output logic                          ready_o,
    output logic [NUM_RD-1:0]             parity_err_o
);

`ifdef REGFILE_PARITY_EN
    localparam int SW = DATA_WIDTH + 1;
`else
    localparam int SW = DATA_WIDTH;
`endif

    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_IDX);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_IDX   = AW'(1);

    rf_state_e     state_q;
    logic [AW-1:0] clr_idx_q;
    logic          ready_q;
    logic [SW-1:0] mem_q [DEPTH];
    logic          run_s;
    logic          wr_ok_s;

`ifdef REGFILE_PARITY_EN
    function automatic logic even_par(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Storage word for a data value, with its parity bit when enabled
    function automatic logic [SW-1:0] pack_word(input logic [DATA_WIDTH-1:0] d);
`ifdef REGFILE_PARITY_EN
        return {even_par(d), d};
`else
        return d;
`endif
    endfunction

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    assign run_s   = (state_q == RF_RUN);
    assign wr_ok_s = wr_en_i && (wr_addr_i != ZERO_ADDR) && addr_ok(wr_addr_i);
    assign ready_o = ready_q;

    // Clear sequencer: walk every entry once after reset, then run forever
    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= RF_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + ONE_IDX;
                        ready_q   <= 1'b0;
                    end
                end
                RF_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= RF_CLEAR;
                    clr_idx_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: zeroes from the sequencer in CLEAR, port writes in RUN
    always_ff @(posedge clk_i) begin
        if (state_q == RF_CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_ok_s) begin
            mem_q[wr_addr_i] <= pack_word(wr_data_i);
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .reset_l_i  (reset_l_i),
        .run_i      (run_s),
        .flush_i    (flush_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_busy_o  (rd_busy_o)
    );

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0] addr_s;
            logic          valid_s;
            logic          hit_s;
            logic [SW-1:0] word_s;
            assign addr_s  = rd_addr_i[p*AW +: AW];
            assign valid_s = run_s && (addr_s != ZERO_ADDR) && addr_ok(addr_s);
            assign hit_s   = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_s);
            assign word_s  = mem_q[addr_s];
            assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] =
                !valid_s ? {DATA_WIDTH{1'b0}} :
                hit_s    ? wr_data_i : word_s[DATA_WIDTH-1:0];
`ifdef REGFILE_PARITY_EN
            assign parity_err_o[p] = (valid_s && !hit_s) ?
                (word_s[DATA_WIDTH] ^ even_par(word_s[DATA_WIDTH-1:0])) : 1'b0;
`else
            assign parity_err_o[p] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_multiport;

    localparam int K_DATA   = 0;
    localparam int K_BUSY   = 1;
    localparam int K_READY  = 2;
    localparam int K_PERR   = 3;
    localparam int K_NBDATA = 4;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_l_i;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic        ready;
    logic [1:0]  perr;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic        nb_ready;
    logic [1:0]  nb_perr;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    regfile_multiport dut (
        .clk_i(clk_i), .reset_l_i(reset_l_i), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_busy_o(rd_busy), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
        .rsv_addr_i(rsv_addr), .flush_i(flush), .ready_o(ready),
        .parity_err_o(perr)
    );

    regfile_multiport #(.BYPASS(0)) dut_nb (
        .clk_i(clk_i), .reset_l_i(reset_l_i), .rd_addr_i(rd_addr),
        .rd_data_o(nb_rd_data), .rd_busy_o(nb_rd_busy), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
        .rsv_addr_i(rsv_addr), .flush_i(flush), .ready_o(nb_ready),
        .parity_err_o(nb_perr)
    );

    // Monitor: compare every queued expectation against the current outputs
    always @(negedge clk_i) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_DATA:   mon_act = rd_data[mon_e.port*32 +: 32];
                K_BUSY:   mon_act = {31'd0, rd_busy[mon_e.port]};
                K_READY:  mon_act = {31'd0, ready};
                K_PERR:   mon_act = {31'd0, perr[mon_e.port]};
                K_NBDATA: mon_act = nb_rd_data[mon_e.port*32 +: 32];
                default:  mon_act = 32'hxxxx_xxxx;
            endcase
            n_cmp++;
            if (mon_act !== mon_e.exp) begin
                n_err++;
                $display("FAIL %s port%0d: actual %h required %h",
                         mon_e.name, mon_e.port, mon_act, mon_e.exp);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [31:0] v,
                        input string nm);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    // Release reset and run a full clear, with writes/reserves attempted during it
    task automatic clear_phase(input logic [31:0] junk);
        reset_l_i = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            if (k <= 32) begin
                wr_en = 1'b1; wr_addr = 5'd5; wr_data = junk;
                rsv_en = 1'b1; rsv_addr = 5'd3;
            end else begin
                idle();
            end
            rd(5'd5, 5'd3);
            push(K_READY, 0, (k == 33) ? 32'd1 : 32'd0, "ready_seq");
            push(K_DATA, 0, 32'd0, "clr_rd5");
            push(K_BUSY, 1, 32'd0, "clr_busy3");
            cyc();
        end
    endtask

    initial begin
        reset_l_i = 1'b0;
        rd_addr = 10'd0; wr_addr = 5'd0; wr_data = 32'd0; rsv_addr = 5'd0;
        idle();
        cyc();

        // Held in reset: everything zero
        for (int k = 0; k < 3; k++) begin
            rd(5'd5, 5'd7);
            push(K_READY, 0, 32'd0, "rst_ready");
            push(K_DATA, 0, 32'd0, "rst_data0");
            push(K_DATA, 1, 32'd0, "rst_data1");
            push(K_BUSY, 0, 32'd0, "rst_busy0");
            push(K_PERR, 1, 32'd0, "rst_perr1");
            cyc();
        end

        clear_phase(32'hAAAA_5555);

        // Whole array reads zero after clear
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            push(K_DATA, 0, 32'd0, "scan_data0");
            push(K_DATA, 1, 32'd0, "scan_data1");
            push(K_BUSY, 0, 32'd0, "scan_busy0");
            cyc();
        end

        // Same-cycle bypass of entry 5
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd(5'd5, 5'd6);
        push(K_DATA, 0, 32'hDEAD_BEEF, "byp_same");
        push(K_NBDATA, 0, 32'd0, "nobyp_same");
        push(K_BUSY, 0, 32'd0, "byp_busy");
        push(K_DATA, 1, 32'd0, "byp_other");
        cyc();
        idle();
        push(K_DATA, 0, 32'hDEAD_BEEF, "byp_next");
        push(K_NBDATA, 0, 32'hDEAD_BEEF, "nobyp_next");
        cyc();

        // Entry 0 is hardwired zero, never busy
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; rd(5'd0, 5'd5);
        push(K_DATA, 0, 32'd0, "zero_wr_byp");
        push(K_NBDATA, 0, 32'd0, "zero_wr_nb");
        push(K_DATA, 1, 32'hDEAD_BEEF, "keep5");
        cyc();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd0;
        push(K_DATA, 0, 32'd0, "zero_rd");
        cyc();
        idle();
        push(K_BUSY, 0, 32'd0, "zero_busy");
        push(K_DATA, 0, 32'd0, "zero_rd2");
        cyc();

        // Reserve / write interplay on entry 7
        rsv_en = 1'b1; rsv_addr = 5'd7; rd(5'd7, 5'd7);
        push(K_BUSY, 0, 32'd0, "rsv_pre0");
        push(K_BUSY, 1, 32'd0, "rsv_pre1");
        cyc();
        idle();
        push(K_BUSY, 0, 32'd1, "rsv7_b0");
        push(K_BUSY, 1, 32'd1, "rsv7_b1");
        push(K_DATA, 0, 32'd0, "rsv7_d0");
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        push(K_BUSY, 0, 32'd0, "rsvwr_byp_b0");
        push(K_BUSY, 1, 32'd0, "rsvwr_byp_b1");
        push(K_DATA, 0, 32'h77, "rsvwr_byp_d");
        push(K_NBDATA, 0, 32'd0, "rsvwr_nb_d");
        cyc();
        idle();
        push(K_BUSY, 0, 32'd1, "rsv_beats_wr0");
        push(K_BUSY, 1, 32'd1, "rsv_beats_wr1");
        push(K_DATA, 0, 32'h77, "rsvwr_data");
        cyc();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
        push(K_BUSY, 0, 32'd0, "wr7_byp_b");
        push(K_DATA, 0, 32'h78, "wr7_byp_d");
        cyc();
        idle();
        push(K_BUSY, 0, 32'd0, "wr7_clr_b0");
        push(K_BUSY, 1, 32'd0, "wr7_clr_b1");
        push(K_DATA, 1, 32'h78, "wr7_data");
        cyc();

        // Reserve 3 and 9, then flush
        rsv_en = 1'b1; rsv_addr = 5'd3; rd(5'd3, 5'd9);
        push(K_BUSY, 0, 32'd0, "r3_pre");
        cyc();
        rsv_addr = 5'd9;
        push(K_BUSY, 0, 32'd1, "r3_set");
        push(K_BUSY, 1, 32'd0, "r9_pre");
        cyc();
        idle(); flush = 1'b1;
        push(K_BUSY, 0, 32'd1, "r3_preflush");
        push(K_BUSY, 1, 32'd1, "r9_preflush");
        cyc();
        idle();
        push(K_BUSY, 0, 32'd0, "flush3");
        push(K_BUSY, 1, 32'd0, "flush9");
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd3; flush = 1'b1;
        cyc();
        idle();
        push(K_BUSY, 0, 32'd0, "flush_beats_rsv");
        cyc();

        // Parity: write 4=1, 2=3, optionally corrupt entry 4
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h1;
        cyc();
        wr_addr = 5'd2; wr_data = 32'h3;
        cyc();
        idle(); rd(5'd4, 5'd2);
`ifdef REGFILE_PARITY_EN
        dut.mem_q[4][1] = ~dut.mem_q[4][1];
        push(K_PERR, 0, 32'd1, "perr_flip4");
`else
        push(K_DATA, 0, 32'h1, "rd4");
        push(K_PERR, 0, 32'd0, "perr4_off");
`endif
        push(K_PERR, 1, 32'd0, "perr2");
        push(K_DATA, 1, 32'h3, "rd2");
        cyc();

        // Reset 10 cycles into a clear sequence, then a full fresh clear
        reset_l_i = 1'b0; rd(5'd5, 5'd7);
        push(K_READY, 0, 32'd0, "rst2_ready");
        push(K_DATA, 0, 32'd0, "rst2_data");
        cyc();
        reset_l_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
            push(K_READY, 0, 32'd0, "part_clear");
            cyc();
        end
        idle(); reset_l_i = 1'b0;
        push(K_READY, 0, 32'd0, "rst3_ready");
        cyc();
        clear_phase(32'h0000_0055);
        rd(5'd7, 5'd2);
        push(K_DATA, 0, 32'd0, "reclr_rd7");
        push(K_DATA, 1, 32'd0, "reclr_rd2");
        push(K_BUSY, 0, 32'd0, "reclr_busy7");
        cyc();

        // Drain check: monitor must have consumed every expectation
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: actual %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
